cache_write_arbiter: RTL and testbench

- Shares one cache AXI write-channel engine between N write requesters, e.g. a write-through buffer and a write-back victim path.
- Uses round-robin arbitration.
- Captures the winning request into a holding register and drives the engine's valid/addr/wdata/wstrb interface.
- Holds the payload stable until the engine signals completion, because the engine reads the payload combinationally through its address, write and response phases.
- Includes a completion watchdog.

---
 rtl/cache_write_arbiter_pkg.sv | 17 +
 rtl/cache_write_arbiter_rr_pick.sv | 37 +++
 rtl/cache_write_arbiter.sv | 135 +++++++++++++
 tb/tb_cache_write_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_write_arbiter_pkg.sv
// Shared types for the cache write arbiter and its round-robin picker.
//   arb_state_t : FSM encoding (IDLE=0, ISSUE=1, WAIT=2)
//   gid_width() : bit width needed to name one of n requesters
package cache_write_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Never returns 0, so a grant index is at least one bit wide.
  function automatic int gid_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cache_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// searching cyclically. Shared with the read-side arbiter.
// Ports:
//   req_valid  in   N_REQ  request valids
//   rr_ptr     in   GW     highest-priority index (must be < N_REQ)
//   winner     out  GW     selected index (0 when none valid)
//   any_valid  out  1      at least one request valid
module rr_pick
  import cache_write_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int GW    = gid_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [GW-1:0]    rr_ptr,
  output logic [GW-1:0]    winner,
  output logic             any_valid
);

  // Walk from the farthest offset back to offset 0 so that the nearest
  // valid requester is the last to overwrite winner.
  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[idx]) begin
        winner    = GW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_write_arbiter.sv
// Round-robin arbiter sharing one cache write engine between N_REQ requesters.
// The winning request is captured into a holding register and held stable
// until the engine signals completion, since the engine reads it combinationally
// across its address, write and response phases.
// Ports:
//   ap_clk, reset         clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake; ready is a one-hot pop
//   req_addr/wdata/wstrb  packed request payloads, requester i in slice i
//   dn_valid/dn_ready     engine handshake; dn_ready in WAIT means done
//   dn_addr/wdata/wstrb   held payload
//   grant_id              owner of the current transfer
//   busy                  a transfer is held
//   timeout_err           sticky watchdog flag
//
// state | meaning
// IDLE  | no transfer held; pop a winner when any request is valid
// ISSUE | dn_valid high, waiting for engine acceptance
// WAIT  | accepted, waiting for engine completion (dn_ready)
module cache_write_arbiter
  import cache_write_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NBYTES    = 4,
  parameter int TIMEOUT_W = 12
) (
  input  logic                        ap_clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_W-1:0]     req_addr,
  input  logic [N_REQ*DATA_W-1:0]     req_wdata,
  input  logic [N_REQ*NBYTES-1:0]     req_wstrb,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        dn_valid,
  output logic [ADDR_W-1:0]           dn_addr,
  output logic [DATA_W-1:0]           dn_wdata,
  output logic [NBYTES-1:0]           dn_wstrb,
  input  logic                        dn_ready,
  output logic [gid_width(N_REQ)-1:0] grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int GW = gid_width(N_REQ);
  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

  arb_state_t           state;
  logic [GW-1:0]        rr_ptr;
  logic [GW-1:0]        winner;
  logic                 any_valid;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [NBYTES-1:0]    sel_wstrb;

  rr_pick #(.N_REQ(N_REQ), .GW(GW)) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == GW'(i)) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_wstrb = req_wstrb[i*NBYTES +: NBYTES];
      end
    end
  end

  // The pop is combinational; gate it with reset so nothing is taken while
  // the block (and the engine) is being reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = !reset && (state == IDLE) && any_valid && (winner == GW'(i));
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge ap_clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      dn_valid    <= 1'b0;
      dn_addr     <= '0;
      dn_wdata    <= '0;
      dn_wstrb    <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      // Watchdog only observes; it never aborts the held transfer.
      if (state != IDLE) begin
        if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt == WD_MAX - 1'b1) timeout_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (any_valid) begin
            dn_addr  <= sel_addr;
            dn_wdata <= sel_wdata;
            dn_wstrb <= sel_wstrb;
            grant_id <= winner;
            rr_ptr   <= (winner == GW'(N_REQ - 1)) ? '0 : winner + 1'b1;
            dn_valid <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (dn_ready) begin
            dn_valid <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (dn_ready) state <= IDLE;
        end
        default: begin
          dn_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_write_arbiter.sv
// Directed bench for cache_write_arbiter (N_REQ=4, TIMEOUT_W=4).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_cache_write_arbiter;

  logic         ap_clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wstrb;
  logic [3:0]   req_ready;
  logic         dn_valid;
  logic [31:0]  dn_addr;
  logic [31:0]  dn_wdata;
  logic [3:0]   dn_wstrb;
  logic         dn_ready;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int failures = 0;
  int pop_q[$];

  cache_write_arbiter #(
    .N_REQ(4), .ADDR_W(32), .DATA_W(32), .NBYTES(4), .TIMEOUT_W(4)
  ) dut (
    .ap_clk(ap_clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_ready(req_ready),
    .dn_valid(dn_valid), .dn_addr(dn_addr), .dn_wdata(dn_wdata),
    .dn_wstrb(dn_wstrb), .dn_ready(dn_ready),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // Records every pop (valid & ready at the active edge) in order.
  always @(posedge ap_clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) pop_q.push_back(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit expired");
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
    req_wstrb[i*4 +: 4]   = s;
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    reset = 1'b1;
    req_valid = '0;
    dn_ready = 1'b0;
    repeat (2) @(negedge ap_clk);
    reset = 1'b0;
    pop_q.delete();
  endtask

  task automatic test_reset();
    @(negedge ap_clk);
    reset = 1'b1;
    req_valid = 4'b0001;
    dn_ready = 1'b0;
    repeat (2) @(negedge ap_clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    checks++; if (dn_valid !== 1'b0) begin failures++; $display("FAIL rst_dn_valid got=%0h exp=0", dn_valid); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_req_ready got=%0h exp=0", req_ready); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_grant_id got=%0h exp=0", grant_id); end
    checks++; if (dn_addr !== 32'h0 || dn_wdata !== 32'h0 || dn_wstrb !== 4'h0) begin failures++; $display("FAIL rst_payload got=%0h/%0h/%0h exp=0/0/0", dn_addr, dn_wdata, dn_wstrb); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%0h exp=0", timeout_err); end
    req_valid = '0;
    reset = 1'b0;
    pop_q.delete();
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 32'h100, 32'hDEADBEEF, 4'hF);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_pop got=%0h exp=1", req_ready); end
    @(negedge ap_clk);
    req_valid = '0;
    dn_ready = 1'b1;
    #1;
    checks++; if (dn_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL single_issue got=%0h/%0h exp=1/1", dn_valid, busy); end
    checks++; if (dn_addr !== 32'h100 || dn_wdata !== 32'hDEADBEEF || dn_wstrb !== 4'hF) begin failures++; $display("FAIL single_payload got=%0h/%0h/%0h exp=100/deadbeef/f", dn_addr, dn_wdata, dn_wstrb); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL single_grant got=%0h exp=0", grant_id); end
    @(negedge ap_clk);
    dn_ready = 1'b0;
    set_req(0, 32'h555, 32'h01234567, 4'h1);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (dn_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_wait%0d got=%0h/%0h exp=0/1", c, dn_valid, busy); end
      checks++; if (dn_addr !== 32'h100 || dn_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_hold%0d got=%0h/%0h exp=100/deadbeef", c, dn_addr, dn_wdata); end
      @(negedge ap_clk);
    end
    dn_ready = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_at_done got=%0h exp=1", busy); end
    @(negedge ap_clk);
    dn_ready = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || dn_valid !== 1'b0) begin failures++; $display("FAIL single_idle got=%0h/%0h exp=0/0", busy, dn_valid); end
    checks++; if (pop_q.size() != 1 || pop_q[0] != 0) begin failures++; $display("FAIL single_pop_count got=%0d exp=1", pop_q.size()); end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int cyc;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'h1000 + i*16, 32'hA0 + i, 4'hF);
    req_valid = 4'b1111;
    dn_ready = 1'b1;
    cyc = 0;
    while (pop_q.size() < 5 && cyc < 40) begin
      @(negedge ap_clk);
      cyc++;
    end
    req_valid = '0;
    repeat (3) @(negedge ap_clk);
    dn_ready = 1'b0;
    #1;
    checks++; if (pop_q.size() != 5) begin failures++; $display("FAIL rr_pop_count got=%0d exp=5", pop_q.size()); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (k >= pop_q.size() || pop_q[k] != exp_order[k]) begin failures++; $display("FAIL rr_order%0d got=%0d exp=%0d", k, (k < pop_q.size()) ? pop_q[k] : -1, exp_order[k]); end
    end
    checks++; if (dn_addr !== 32'h1000 || busy !== 1'b0) begin failures++; $display("FAIL rr_last got=%0h/%0h exp=1000/0", dn_addr, busy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 32'hA00, 32'h0A0A0A0A, 4'hF);
    set_req(1, 32'hB00, 32'h0B0B0B0B, 4'hF);
    set_req(2, 32'h2A0, 32'h12345678, 4'h3);
    set_req(3, 32'h3C0, 32'hCAFEF00D, 4'hC);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_pop got=%0h exp=4", req_ready); end
    @(negedge ap_clk);
    req_valid = 4'b1011;
    dn_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (dn_valid !== 1'b1 || req_ready !== 4'b0000) begin failures++; $display("FAIL bp_hold%0d got=%0h/%0h exp=1/0", c, dn_valid, req_ready); end
      checks++; if (dn_addr !== 32'h2A0 || dn_wdata !== 32'h12345678 || dn_wstrb !== 4'h3 || grant_id !== 2'd2) begin failures++; $display("FAIL bp_payload%0d got=%0h/%0h/%0h/%0h exp=2a0/12345678/3/2", c, dn_addr, dn_wdata, dn_wstrb, grant_id); end
      @(negedge ap_clk);
    end
    dn_ready = 1'b1;
    @(negedge ap_clk);
    @(negedge ap_clk);
    dn_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL bp_next_pop got=%0h exp=8", req_ready); end
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    checks++; if (grant_id !== 2'd3 || dn_addr !== 32'h3C0 || dn_wstrb !== 4'hC) begin failures++; $display("FAIL bp_next_grant got=%0h/%0h/%0h exp=3/3c0/c", grant_id, dn_addr, dn_wstrb); end
    checks++; if (pop_q.size() != 2) begin failures++; $display("FAIL bp_pop_count got=%0d exp=2", pop_q.size()); end
  endtask

  task automatic test_wait_arrival();
    do_reset();
    set_req(0, 32'h400, 32'h0BADF00D, 4'hF);
    set_req(1, 32'h500, 32'h11112222, 4'h7);
    req_valid = 4'b0001;
    @(negedge ap_clk);
    req_valid = '0;
    dn_ready = 1'b1;
    @(negedge ap_clk);
    dn_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL wa_wait1 got=%0h/%0h exp=0/1", req_ready, busy); end
    @(negedge ap_clk);
    dn_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL wa_at_done got=%0h exp=0", req_ready); end
    @(negedge ap_clk);
    dn_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010 || busy !== 1'b0) begin failures++; $display("FAIL wa_pop got=%0h/%0h exp=2/0", req_ready, busy); end
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    checks++; if (grant_id !== 2'd1 || dn_addr !== 32'h500 || dn_wdata !== 32'h11112222 || dn_valid !== 1'b1) begin failures++; $display("FAIL wa_grant got=%0h/%0h/%0h/%0h exp=1/500/11112222/1", grant_id, dn_addr, dn_wdata, dn_valid); end
    checks++; if (pop_q.size() != 2 || pop_q[1] != 1) begin failures++; $display("FAIL wa_pop_count got=%0d exp=2", pop_q.size()); end
  endtask

  task automatic test_watchdog();
    do_reset();
    set_req(0, 32'h700, 32'h77777777, 4'hF);
    req_valid = 4'b0001;
    @(negedge ap_clk);
    req_valid = '0;
    dn_ready = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge ap_clk);
      dn_ready = 1'b0;
      #1;
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL wd_early%0d got=%0h exp=0", k, timeout_err); end
    end
    @(negedge ap_clk);
    #1;
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL wd_fire got=%0h/%0h exp=1/1", timeout_err, busy); end
    repeat (3) @(negedge ap_clk);
    #1;
    checks++; if (timeout_err !== 1'b1 || dn_addr !== 32'h700) begin failures++; $display("FAIL wd_sat got=%0h/%0h exp=1/700", timeout_err, dn_addr); end
    dn_ready = 1'b1;
    @(negedge ap_clk);
    dn_ready = 1'b0;
    #1;
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL wd_sticky got=%0h/%0h exp=1/0", timeout_err, busy); end
    do_reset();
    #1;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL wd_reset_clear got=%0h exp=0", timeout_err); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    set_req(0, 32'h800, 32'h88888888, 4'hF);
    set_req(1, 32'h600, 32'h66666666, 4'hF);
    set_req(2, 32'h900, 32'h99999999, 4'hF);
    req_valid = 4'b0010;
    @(negedge ap_clk);
    req_valid = '0;
    dn_ready = 1'b1;
    @(negedge ap_clk);
    dn_ready = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin failures++; $display("FAIL rmw_in_wait got=%0h/%0h exp=1/1", busy, grant_id); end
    reset = 1'b1;
    req_valid = 4'b0101;
    @(negedge ap_clk);
    #1;
    checks++; if (busy !== 1'b0 || dn_valid !== 1'b0 || grant_id !== 2'd0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rmw_state got=%0h/%0h/%0h/%0h exp=0/0/0/0", busy, dn_valid, grant_id, timeout_err); end
    checks++; if (dn_addr !== 32'h0 || dn_wdata !== 32'h0 || dn_wstrb !== 4'h0 || req_ready !== 4'h0) begin failures++; $display("FAIL rmw_payload got=%0h/%0h/%0h/%0h exp=0/0/0/0", dn_addr, dn_wdata, dn_wstrb, req_ready); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rmw_first_pop got=%0h exp=1", req_ready); end
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    checks++; if (grant_id !== 2'd0 || dn_addr !== 32'h800) begin failures++; $display("FAIL rmw_grant got=%0h/%0h exp=0/800", grant_id, dn_addr); end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_wdata = '0;
    req_wstrb = '0;
    dn_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wait_arrival();
    test_watchdog();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
